// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, one SLICE-bit slice per clock, MSB slice first.
// Optional macro CMP_EARLY_EXIT_EN: stop on the first differing slice instead of scanning all slices.
module seq_magnitude_comparator #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NSLICE - 1);
   localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CMP  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [IDXW-1:0]  r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_signed;
   logic             r_eq;
   logic             r_gt;
   logic             r_lt;
`ifndef CMP_EARLY_EXIT_EN
   logic             r_found;
   logic             r_found_gt;
`endif

   logic [SLICE-1:0] w_mask;
   logic [SLICE-1:0] w_slice_a;
   logic [SLICE-1:0] w_slice_b;
   logic             w_diff;
   logic             w_slice_gt;
   logic             w_accept;

   assign w_accept = (r_state == S_IDLE) && start;

   // Flipping the sign bit of the top slice maps two's-complement order onto unsigned order.
   assign w_mask     = (r_signed && (r_idx == IDX_TOP)) ? MSB_MASK : '0;
   assign w_slice_a  = r_a[r_idx*SLICE +: SLICE] ^ w_mask;
   assign w_slice_b  = r_b[r_idx*SLICE +: SLICE] ^ w_mask;
   assign w_diff     = (w_slice_a != w_slice_b);
   assign w_slice_gt = (w_slice_a > w_slice_b);

   // NOTE: operand registers are pure datapath, loaded before any use, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_signed <= signed_mode;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= IDX_TOP;
         r_eq    <= 1'b0;
         r_gt    <= 1'b0;
         r_lt    <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
         r_found    <= 1'b0;
         r_found_gt <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_CMP;
                  r_idx   <= IDX_TOP;
`ifndef CMP_EARLY_EXIT_EN
                  r_found <= 1'b0;
`endif
               end
            end
            S_CMP: begin
`ifdef CMP_EARLY_EXIT_EN
               if (w_diff) begin
                  r_state <= S_DONE;
                  r_eq    <= 1'b0;
                  r_gt    <= w_slice_gt;
                  r_lt    <= ~w_slice_gt;
               end else if (r_idx == '0) begin
                  r_state <= S_DONE;
                  r_eq    <= 1'b1;
                  r_gt    <= 1'b0;
                  r_lt    <= 1'b0;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
`else
               // Only the first (most significant) differing slice decides the result.
               if (w_diff && !r_found) begin
                  r_found    <= 1'b1;
                  r_found_gt <= w_slice_gt;
               end
               if (r_idx == '0) begin
                  r_state <= S_DONE;
                  if (r_found) begin
                     r_eq <= 1'b0;
                     r_gt <= r_found_gt;
                     r_lt <= ~r_found_gt;
                  end else if (w_diff) begin
                     r_eq <= 1'b0;
                     r_gt <= w_slice_gt;
                     r_lt <= ~w_slice_gt;
                  end else begin
                     r_eq <= 1'b1;
                     r_gt <= 1'b0;
                     r_lt <= 1'b0;
                  end
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
`endif
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_idx   <= IDX_TOP;
            end
            default: begin
               r_state <= S_IDLE;
               r_idx   <= IDX_TOP;
            end
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);
   assign eq   = r_eq;
   assign gt   = r_gt;
   assign lt   = r_lt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed self-checking bench for seq_magnitude_comparator (WIDTH=16, SLICE=4).
// Expected latencies follow CMP_EARLY_EXIT_EN when the bench is built with it.
module tb_seq_magnitude_comparator;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        signed_mode;
   logic        busy;
   logic        done;
   logic        eq;
   logic        gt;
   logic        lt;

   int n_checks;
   int n_errors;

`ifdef CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam logic [2:0] F_EQ   = 3'b100;
   localparam logic [2:0] F_GT   = 3'b010;
   localparam logic [2:0] F_LT   = 3'b001;
   localparam logic [2:0] F_NONE = 3'b000;

   seq_magnitude_comparator #(
      .WIDTH(16),
      .SLICE(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .signed_mode(signed_mode),
      .busy       (busy),
      .done       (done),
      .eq         (eq),
      .gt         (gt),
      .lt         (lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Launch one compare and time done in cycles after the start edge.
   // With poke set, a start with a=b=0 is pulsed while the engine is busy.
   task automatic run_cmp(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tsm, input logic [2:0] exp_flags, input int exp_k,
                          input bit poke);
      int n;
      int extra;
      @(negedge clk);
      a = ta;
      b = tb_v;
      signed_mode = tsm;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~ta;
      signed_mode = ~tsm;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         if (poke && n == 1) begin
            start = 1'b1;
            a = '0;
            b = '0;
         end else if (poke && n == 2) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_latency"}, n, exp_k);
      check({tag, "_flags"}, {29'd0, eq, gt, lt}, {29'd0, exp_flags});
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      if (poke) begin
         extra = 0;
         repeat (8) begin
            @(negedge clk);
            if (done) extra++;
         end
         check({tag, "_no_second_done"}, extra, 0);
         check({tag, "_flags_kept"}, {29'd0, eq, gt, lt}, {29'd0, exp_flags});
      end
   endtask

   initial begin
      int dones;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      start = 1'b1;
      a = 16'hFFFF;
      b = 16'h0000;
      signed_mode = 1'b0;

      // Reset held two cycles with start asserted.
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_flags", {29'd0, eq, gt, lt}, {29'd0, F_NONE});
      rst = 1'b0;
      start = 1'b0;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      check("rst_release_quiet", dones, 0);

      // Equal operands, then flags must hold while idle.
      run_cmp("eq_unsigned", 16'h1234, 16'h1234, 1'b0, F_EQ, 4, 1'b0);
      repeat (3) @(negedge clk);
      check("eq_hold", {29'd0, eq, gt, lt}, {29'd0, F_EQ});

      run_cmp("gt_unsigned", 16'hD000, 16'h2000, 1'b0, F_GT, EARLY ? 1 : 4, 1'b0);
      run_cmp("lt_signed", 16'hD000, 16'h2000, 1'b1, F_LT, EARLY ? 1 : 4, 1'b0);
      run_cmp("lt_signed_min", 16'h8000, 16'h7FFF, 1'b1, F_LT, EARLY ? 1 : 4, 1'b0);
      run_cmp("gt_unsigned_min", 16'h8000, 16'h7FFF, 1'b0, F_GT, EARLY ? 1 : 4, 1'b0);
      run_cmp("lt_low_slice", 16'h00F1, 16'h00F2, 1'b0, F_LT, 4, 1'b1);

      // Reset on the second CMP cycle abandons the compare.
      @(negedge clk);
      a = 16'h0001;
      b = 16'h0002;
      signed_mode = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      if (done) dones++;
      @(negedge clk);
      if (done) dones++;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_flags", {29'd0, eq, gt, lt}, {29'd0, F_NONE});
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("midrst_no_done", dones, 0);
      run_cmp("eq_after_rst", 16'h0001, 16'h0001, 1'b0, F_EQ, 4, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised multi-cycle magnitude comparator. It is the next generation of the combinational 4-bit eq/gt/lt comparator. It compares two WIDTH-bit operands one SLICE-bit slice per clock, MSB slice first, in unsigned or two's-complement mode. It uses a start/done handshake and registered, held results. It serves as the shared compare engine for lab datapaths whose operands are too wide for a single-cycle compare.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of SLICE.
SLICE, 4, bits compared per clock cycle; NSLICE = WIDTH/SLICE, must be >= 1.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a compare; sampled only in IDLE.
a  input  WIDTH  operand A; latched when start is accepted.
b  input  WIDTH  operand B; latched when start is accepted.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with a/b.
busy  output  1  high while state != IDLE.
done  output  1  one-cycle pulse; result valid and updated.
eq  output  1  a == b (held).
gt  output  1  a > b (held).
lt  output  1  a < b (held).

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: state=IDLE. busy, done, eq, gt and lt are all 0. Slice index = NSLICE-1. Reset overrides every other input, including mid-compare: the operation is abandoned, no done is produced, and the result flags clear.
- FSM has three states: IDLE, CMP, DONE.
- IDLE:
  - start=1 at an edge latches a, b and signed_mode, sets idx=NSLICE-1, and moves to CMP.
  - start=0 stays in IDLE.
- CMP: each edge compares slice idx of the latched operands, i.e. bits [idx*SLICE+SLICE-1 : idx*SLICE].
  - In signed mode, the MSB bit of the top slice (idx=NSLICE-1) is inverted in both operands before comparing. This gives a correct two's-complement order.
  - Slices differ: set gt or lt, move to DONE.
  - Slices equal and idx==0: set eq, move to DONE.
  - Slices equal and idx>0: decrement idx, stay in CMP.
- DONE:
  - done=1 for exactly this one cycle; eq/gt/lt already carry the new result.
  - The next edge returns to IDLE unconditionally.
- Result flags: eq/gt/lt are updated together on the edge that enters DONE. Exactly one is high after any completed compare. They hold their value until the next completion or reset.
- Latency: if the start edge is T0 and k slices are examined (1..NSLICE), done is high in the cycle after edge Tk. The minimum start-to-start interval is k+2 cycles.
- start while busy (CMP or DONE) is ignored, not queued. Changes on a/b/signed_mode after acceptance have no effect on the compare in progress.
- start in the same cycle as rst: reset wins.

Optional Feature:
CMP_EARLY_EXIT_EN:
- Defined: CMP terminates on the first differing slice, so k = number of slices up to and including the first difference (1..NSLICE).
- Undefined: CMP always scans all NSLICE slices, so k = NSLICE for every compare. The first difference found still determines gt/lt; later slices are ignored for the result.
- eq/gt/lt values are identical in both builds; only the done timing differs.

Test Plan:
All scenarios use WIDTH=16, SLICE=4.
- Reset: hold rst for 2 cycles with start=1, a=0xFFFF, b=0 -> busy=0, done=0, eq=gt=lt=0; no done pulse after release while start=0.
- Equal, unsigned: a=0x1234, b=0x1234, start pulse -> done high 4 cycles after the start edge; eq=1, gt=lt=0; flags hold until the next start.
- Unsigned gt: a=0xD000, b=0x2000, signed_mode=0 -> gt=1. done after 1 cycle with CMP_EARLY_EXIT_EN, after 4 cycles without.
- Signed lt: same operands, signed_mode=1 (-12288 vs 8192) -> lt=1, gt=0; also a=0x8000, b=0x7FFF signed -> lt=1.
- Low-slice difference plus busy-start: a=0x00F1, b=0x00F2, unsigned -> lt=1, done at cycle 4. A start pulsed with a=b=0 during CMP is ignored: no second done, and result stays lt.
- Reset mid-operation: a=0x0001, b=0x0002, assert rst on the 2nd CMP cycle -> state returns to IDLE, busy=0, flags=0, and no done ever pulses for that compare. A following start with a=b=0x0001 completes normally with eq=1.
